gnrl_dpram: RTL and testbench
=============================

# gnrl_dpram

Parametrised simple-dual-port SRAM: one write port with byte-lane mask and one read port, both usable every cycle. It is the general-purpose memory primitive for the core's instruction/data RAMs and buffers. It adds, as decided features of this generation: valid/ready handshakes, a post-reset clear sweep, read-during-write bypass, optional output pipeline register, and out-of-range detection.

## Interface
- DP, 512: depth in words
- AW, 32: byte-address width
- DW, 32: word width in bits, any value ≥ 8
- MW, (DW+7)/8: byte lanes; the last lane covers bits DW-1:8*(MW-1) when DW is not a multiple of 8
- ADDR_SHIFT, 2: byte-to-word shift; word index = addr >> ADDR_SHIFT
- OUT_REG, 0: 1 adds an output register stage (read latency 2)
- INIT_CLEAR, 1: 1 zero-fills the whole array after reset
- WR_BYPASS, 1: 1 makes a same-cycle same-index read return the newly written bytes

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid & wr_ready
- wr_addr  in  AW  write byte address
- wr_data  in  DW  write data
- wr_mask  in  MW  per-lane write enable
- rd_valid  in  1  read request
- rd_ready  out  1  read accepted when rd_valid & rd_ready
- rd_addr  in  AW  read byte address
- rsp_valid  out  1  read response strobe, 1 cycle per accepted read
- rsp_data  out  DW  read data
- rsp_err  out  1  response was out of range
- init_busy  out  1  clear sweep in progress

## Operation
- State machine with states INIT and RUN.
  - On reset: enter INIT if INIT_CLEAR=1, otherwise RUN.
  - INIT: a counter starting at 0 writes all-zero to one word per cycle. After word DP-1 is written, the next cycle is RUN.
  - RUN: terminal until the next rst.
- wr_ready = rd_ready = (state == RUN). init_busy = (state == INIT).
- Write: on an accepted write with index < DP, lane i of mem[index] is updated iff wr_mask[i]. A mask of 0 is a legal no-op.
- Write with index ≥ DP: dropped, array unchanged, no error output.
- Read: on an accepted read, the index is captured.
  - Index < DP: rsp_data = mem[index], rsp_err = 0.
  - Index ≥ DP: rsp_data = 0, rsp_err = 1.
- Same-cycle read and write to the same valid index:
  - WR_BYPASS=1: masked lanes return wr_data, unmasked lanes return the old content.
  - WR_BYPASS=0: all lanes return the old content.
- Write and read are independent. Both may be accepted in the same cycle; there is no priority or stall.
- The response path has no backpressure. The consumer must take rsp_* when rsp_valid is asserted.
- rsp_data and rsp_err hold their last value while rsp_valid = 0.

## Timing
- Reset values: rsp_valid=0, rsp_data=0, rsp_err=0. With INIT_CLEAR=1: init_busy=1, wr_ready=0, rd_ready=0. With INIT_CLEAR=0: init_busy=0, ready outputs=1.
- INIT lasts exactly DP cycles after the cycle in which rst is deasserted. Ready outputs rise in cycle DP.
- rst asserted mid-sweep restarts the counter at 0. rst asserted mid-read kills any pending response: rsp_valid=0 the next cycle.
- Read latency: read accepted in cycle T gives rsp_valid in T+1 (OUT_REG=0) or T+2 (OUT_REG=1). Full throughput of one read per cycle, responses in order.
- A write accepted in cycle T is visible to a read accepted in T+1 regardless of WR_BYPASS. Visibility in T itself follows the WR_BYPASS rule above.
- Array contents are not reset when INIT_CLEAR=0.

## Test plan
- DP=16, DW=32, INIT_CLEAR=1: release rst, then read indexes 0..15 -> ready outputs rise exactly 16 cycles after rst drops; every read returns 0x00000000, rsp_err=0.
- Write addr 0x8, data 0xAABBCCDD, mask 4'b1111; then write addr 0x8, data 0x11223344, mask 4'b0101; then read addr 0x8 -> rsp_data=0xAA22CC44 one cycle after read acceptance.
- Same cycle: write addr 0x4, data 0xFFFFFFFF, mask 4'b0011, and read addr 0x4, where the old value is 0x12345678 -> WR_BYPASS=1 returns 0x1234FFFF; WR_BYPASS=0 returns 0x12345678.
- Read addr 0x40 (index 16, DP=16) -> rsp_err=1, rsp_data=0. Write to 0x40 -> no array word changes (checked by a full readback).
- OUT_REG=1: back-to-back reads of addresses 0x0, 0x4, 0x8 -> three consecutive rsp_valid pulses starting at T+2, data in order.
- Assert rst at sweep cycle 7 for 1 cycle, with DW=20 so the last lane is 4 bits wide -> sweep restarts and takes 16 more cycles; then a write of 0xFFFFF with mask 3'b100 and a readback return 0xF0000.

Source files
------------

// File: rtl/gnrl_dpram.sv
// rtl/gnrl_dpram.sv - simple dual-port SRAM with byte-lane write mask, clear sweep and read bypass
module gnrl_dpram #(
    parameter int DP         = 512,
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MW         = (DW + 7) / 8,
    parameter int ADDR_SHIFT = 2,
    parameter int OUT_REG    = 0,
    parameter int INIT_CLEAR = 1,
    parameter int WR_BYPASS  = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [MW-1:0] wr_mask,
    input  logic          rd_valid,
    output logic          rd_ready,
    input  logic [AW-1:0] rd_addr,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic          init_busy
);
    localparam int CW = (DP > 1) ? $clog2(DP) : 1;
    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_mem [DP];

    logic          r_s1_valid, r_s1_err, r_s2_valid, r_s2_err;
    logic [DW-1:0] r_s1_data, r_s2_data;

    logic [AW-1:0] w_wr_idx_full, w_rd_idx_full;
    logic [CW-1:0] w_wr_idx, w_rd_idx;
    logic          w_run, w_wr_acc, w_rd_acc, w_wr_in, w_rd_in, w_hit;
    logic [DW-1:0] w_bitmask, w_rd_old, w_rd_val;

    assign w_run     = (r_state == S_RUN);
    assign wr_ready  = w_run;
    assign rd_ready  = w_run;
    assign init_busy = (r_state == S_INIT);
    assign w_wr_acc  = wr_valid & w_run;
    assign w_rd_acc  = rd_valid & w_run;

    assign w_wr_idx_full = wr_addr >> ADDR_SHIFT;
    assign w_rd_idx_full = rd_addr >> ADDR_SHIFT;
    assign w_wr_in       = (w_wr_idx_full < AW'(DP));
    assign w_rd_in       = (w_rd_idx_full < AW'(DP));
    assign w_wr_idx      = w_wr_idx_full[CW-1:0];
    assign w_rd_idx      = w_rd_idx_full[CW-1:0];

    // Lane i drives bits 8i..8i+7; a narrow top lane simply has fewer bits.
    always_comb begin
        w_bitmask = '0;
        for (int b = 0; b < DW; b++) begin
            w_bitmask[b] = wr_mask[b / 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= (INIT_CLEAR != 0) ? S_INIT : S_RUN;
            r_cnt   <= '0;
        end else if (r_state == S_INIT) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(DP - 1)) begin
                r_state <= S_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == S_INIT) begin
                r_mem[r_cnt] <= '0;
            end else if (w_wr_acc && w_wr_in) begin
                r_mem[w_wr_idx] <= (r_mem[w_wr_idx] & ~w_bitmask) | (wr_data & w_bitmask);
            end
        end
    end

    // Bypass merges only the lanes being written this cycle; the rest come from the array.
    assign w_rd_old = w_rd_in ? r_mem[w_rd_idx] : '0;
    assign w_hit    = (WR_BYPASS != 0) && w_wr_acc && w_wr_in && w_rd_in
                      && (w_wr_idx_full == w_rd_idx_full);
    assign w_rd_val = w_hit ? ((w_rd_old & ~w_bitmask) | (wr_data & w_bitmask)) : w_rd_old;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_err   <= 1'b0;
        end else begin
            r_s1_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_s1_data <= w_rd_val;
                r_s1_err  <= ~w_rd_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_err   <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= r_s1_data;
                r_s2_err  <= r_s1_err;
            end
        end
    end

    assign rsp_valid = (OUT_REG != 0) ? r_s2_valid : r_s1_valid;
    assign rsp_data  = (OUT_REG != 0) ? r_s2_data  : r_s1_data;
    assign rsp_err   = (OUT_REG != 0) ? r_s2_err   : r_s1_err;
endmodule

// File: tb/tb_gnrl_dpram.sv
// tb/tb_gnrl_dpram.sv - scoreboard bench for gnrl_dpram in three configurations
module tb_gnrl_dpram;
    typedef struct {
        logic [31:0] d;
        logic        e;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0;
    int n_err = 0;
    exp_t qa[$], qb[$], qc[$];
    logic [31:0] model [16];

    // A and B share stimulus: A = bypass, 1-cycle; B = no bypass, output register.
    logic        ab_rst = 1'b1, ab_wr_valid = 1'b0, ab_rd_valid = 1'b0;
    logic [31:0] ab_wr_addr = '0, ab_wr_data = '0, ab_rd_addr = '0;
    logic [3:0]  ab_wr_mask = '0;
    logic        a_wr_ready, a_rd_ready, a_rsp_valid, a_rsp_err, a_init_busy;
    logic        b_wr_ready, b_rd_ready, b_rsp_valid, b_rsp_err, b_init_busy;
    logic [31:0] a_rsp_data, b_rsp_data;

    logic        c_rst = 1'b1, c_wr_valid = 1'b0, c_rd_valid = 1'b0;
    logic [31:0] c_wr_addr = '0, c_rd_addr = '0;
    logic [19:0] c_wr_data = '0, c_rsp_data;
    logic [2:0]  c_wr_mask = '0;
    logic        c_wr_ready, c_rd_ready, c_rsp_valid, c_rsp_err, c_init_busy;

    gnrl_dpram #(.DP(16), .OUT_REG(0), .WR_BYPASS(1)) u_a (
        .clk(clk), .rst(ab_rst), .wr_valid(ab_wr_valid), .wr_ready(a_wr_ready),
        .wr_addr(ab_wr_addr), .wr_data(ab_wr_data), .wr_mask(ab_wr_mask),
        .rd_valid(ab_rd_valid), .rd_ready(a_rd_ready), .rd_addr(ab_rd_addr),
        .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .rsp_err(a_rsp_err),
        .init_busy(a_init_busy));

    gnrl_dpram #(.DP(16), .OUT_REG(1), .WR_BYPASS(0)) u_b (
        .clk(clk), .rst(ab_rst), .wr_valid(ab_wr_valid), .wr_ready(b_wr_ready),
        .wr_addr(ab_wr_addr), .wr_data(ab_wr_data), .wr_mask(ab_wr_mask),
        .rd_valid(ab_rd_valid), .rd_ready(b_rd_ready), .rd_addr(ab_rd_addr),
        .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_err(b_rsp_err),
        .init_busy(b_init_busy));

    gnrl_dpram #(.DP(16), .DW(20), .OUT_REG(0)) u_c (
        .clk(clk), .rst(c_rst), .wr_valid(c_wr_valid), .wr_ready(c_wr_ready),
        .wr_addr(c_wr_addr), .wr_data(c_wr_data), .wr_mask(c_wr_mask),
        .rd_valid(c_rd_valid), .rd_ready(c_rd_ready), .rd_addr(c_rd_addr),
        .rsp_valid(c_rsp_valid), .rsp_data(c_rsp_data), .rsp_err(c_rsp_err),
        .init_busy(c_init_busy));

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) o[8*i +: 8] = n[8*i +: 8];
        return o;
    endfunction

    task automatic ab_op(input logic wv, input logic [31:0] wa, input logic [31:0] wd,
                         input logic [3:0] wm, input logic rv, input logic [31:0] ra);
        exp_t ea, eb;
        int wi, ri;
        ab_wr_valid = wv; ab_wr_addr = wa; ab_wr_data = wd; ab_wr_mask = wm;
        ab_rd_valid = rv; ab_rd_addr = ra;
        wi = int'(wa >> 2);
        ri = int'(ra >> 2);
        if (rv) begin
            if (ri >= 16) begin
                ea.d = '0; ea.e = 1'b1; eb.d = '0; eb.e = 1'b1;
            end else begin
                ea.d = (wv && wi == ri) ? merge(model[ri], wd, wm) : model[ri];
                eb.d = model[ri];
                ea.e = 1'b0; eb.e = 1'b0;
            end
            ea.cyc = cyc + 1;
            eb.cyc = cyc + 2;
            qa.push_back(ea);
            qb.push_back(eb);
        end
        if (wv && wi < 16) model[wi] = merge(model[wi], wd, wm);
        @(posedge clk); #1;
        ab_wr_valid = 1'b0; ab_rd_valid = 1'b0;
    endtask

    task automatic ab_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        ab_op(1'b1, a, d, m, 1'b0, '0);
    endtask

    task automatic ab_rd(input logic [31:0] a);
        ab_op(1'b0, '0, '0, '0, 1'b1, a);
    endtask

    task automatic c_op(input logic wv, input logic [31:0] wa, input logic [19:0] wd,
                        input logic [2:0] wm, input logic rv, input logic [31:0] ra,
                        input logic [19:0] xd, input logic xe);
        exp_t e;
        c_wr_valid = wv; c_wr_addr = wa; c_wr_data = wd; c_wr_mask = wm;
        c_rd_valid = rv; c_rd_addr = ra;
        if (rv) begin
            e.d = {12'h0, xd}; e.e = xe; e.cyc = cyc + 1;
            qc.push_back(e);
        end
        @(posedge clk); #1;
        c_wr_valid = 1'b0; c_rd_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (a_rsp_valid) begin
            n_chk++;
            if (qa.size() == 0) begin
                n_err++; $display("FAIL a_rsp unexpected got=%h", a_rsp_data);
            end else begin
                e = qa.pop_front();
                if (a_rsp_data !== e.d || a_rsp_err !== e.e || cyc != e.cyc) begin
                    n_err++;
                    $display("FAIL a_rsp got d=%h e=%b cyc=%0d want d=%h e=%b cyc=%0d",
                             a_rsp_data, a_rsp_err, cyc, e.d, e.e, e.cyc);
                end
            end
        end
        if (b_rsp_valid) begin
            n_chk++;
            if (qb.size() == 0) begin
                n_err++; $display("FAIL b_rsp unexpected got=%h", b_rsp_data);
            end else begin
                e = qb.pop_front();
                if (b_rsp_data !== e.d || b_rsp_err !== e.e || cyc != e.cyc) begin
                    n_err++;
                    $display("FAIL b_rsp got d=%h e=%b cyc=%0d want d=%h e=%b cyc=%0d",
                             b_rsp_data, b_rsp_err, cyc, e.d, e.e, e.cyc);
                end
            end
        end
        if (c_rsp_valid) begin
            n_chk++;
            if (qc.size() == 0) begin
                n_err++; $display("FAIL c_rsp unexpected got=%h", c_rsp_data);
            end else begin
                e = qc.pop_front();
                if ({12'h0, c_rsp_data} !== e.d || c_rsp_err !== e.e || cyc != e.cyc) begin
                    n_err++;
                    $display("FAIL c_rsp got d=%h e=%b cyc=%0d want d=%h e=%b cyc=%0d",
                             c_rsp_data, c_rsp_err, cyc, e.d, e.e, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < 16; i++) model[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset init_busy", {31'h0, a_init_busy}, 32'h1);
        chk("reset wr_ready", {30'h0, a_wr_ready, b_rd_ready}, 32'h0);
        chk("reset rsp_valid", {30'h0, a_rsp_valid, b_rsp_valid}, 32'h0);
        chk("reset rsp_data", a_rsp_data | b_rsp_data, 32'h0);
        chk("reset rsp_err", {30'h0, a_rsp_err, b_rsp_err}, 32'h0);

        ab_rst = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!a_wr_ready && n < 40);
        chk("init cycles", n, 16);
        chk("init ready b", {29'h0, b_wr_ready, a_rd_ready, b_init_busy}, 32'h6);

        for (int i = 0; i < 16; i++) ab_rd(32'(i * 4));

        ab_wr(32'h8, 32'hAABBCCDD, 4'b1111);
        ab_wr(32'h8, 32'h11223344, 4'b0101);
        ab_wr(32'h8, 32'h99999999, 4'b0000);
        ab_rd(32'h8);
        repeat (3) @(posedge clk);
        #1;
        chk("hold a_rsp_data", a_rsp_data, 32'hAA22CC44);
        chk("hold b_rsp_data", b_rsp_data, 32'hAA22CC44);

        ab_wr(32'h4, 32'h12345678, 4'b1111);
        ab_op(1'b1, 32'h4, 32'hFFFFFFFF, 4'b0011, 1'b1, 32'h4);
        ab_rd(32'h4);
        ab_op(1'b1, 32'h10, 32'h5A5A5A5A, 4'b1111, 1'b1, 32'hC);

        ab_rd(32'h40);
        ab_wr(32'h40, 32'hDEADBEEF, 4'b1111);
        for (int i = 0; i < 16; i++) ab_rd(32'(i * 4));

        ab_rd(32'h0);
        ab_rd(32'h4);
        ab_rd(32'h8);
        repeat (4) @(posedge clk);
        #1;

        c_rst = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("c mid-sweep busy", {31'h0, c_init_busy}, 32'h1);
        c_rst = 1'b1;
        @(posedge clk); #1;
        c_rst = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!c_wr_ready && n < 40);
        chk("c restart cycles", n, 16);
        c_op(1'b0, '0, '0, '0, 1'b1, 32'h4, 20'h0, 1'b0);
        c_op(1'b1, 32'h4, 20'hFFFFF, 3'b100, 1'b0, '0, '0, 1'b0);
        c_op(1'b0, '0, '0, '0, 1'b1, 32'h4, 20'hF0000, 1'b0);
        c_op(1'b0, '0, '0, '0, 1'b1, 32'h40, 20'h0, 1'b1);
        repeat (4) @(posedge clk);
        #1;

        chk("qa drained", qa.size(), 0);
        chk("qb drained", qb.size(), 0);
        chk("qc drained", qc.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
